paced_data_synchronizer: RTL and testbench

//  Parametrised successor of the paced FIFO release stage between the energy-detector datapath and host framing.

---
 rtl/paced_data_synchronizer.sv | 181 ++++++++++++++++++
 tb/tb_paced_data_synchronizer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/paced_data_synchronizer.sv
// Paced release stage: buffers dv_in samples in a FIFO and releases them on a
// programmable period tick (single word or burst per tick), or immediately in
// passthrough mode. Optional feature macro: SYNC_UNDERRUN_CNT_EN adds an
// underrun_cnt output counting empty ticks and truncated bursts.
module paced_data_synchronizer #(
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned SR_ADDR    = 0,
   parameter int unsigned DEF_PERIOD = 9
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  set_stb,
   input  logic [7:0]            set_addr,
   input  logic [31:0]           set_data,
   input  logic [DWIDTH-1:0]     data_in,
   input  logic                  dv_in,
   output logic [DWIDTH-1:0]     data_out,
   output logic                  dv_out,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  overflow
`ifdef SYNC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]           underrun_cnt
`endif
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, PASS} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   period_q, cnt_q;
   logic                   enable_q, mode_q;
   logic [7:0]             burst_q, rem_q, rem_d, burst_eff_c;
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [DWIDTH-1:0]      mem [DEPTH];

   logic period_wr_c, ctrl_wr_c, ovf_clr_c;
   logic empty_c, full_c, counting_c, tick_c;
   logic rd_c, wr_acc_c, ovf_set_c, underrun_evt_c;
   logic unused_c;

   assign period_wr_c = set_stb && (set_addr == 8'(SR_ADDR));
   assign ctrl_wr_c   = set_stb && (set_addr == 8'(SR_ADDR + 1));
   assign ovf_clr_c   = ctrl_wr_c && set_data[2];
   assign unused_c    = ^{set_data[31:16], set_data[7:3]};

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   assign counting_c  = (state_q == WAIT) || (state_q == BURST);
   assign tick_c      = counting_c && (cnt_q == period_q) && !period_wr_c;
   assign burst_eff_c = (burst_q == 8'd0) ? 8'd1 : burst_q;

   // A read frees a slot, so a write while full is accepted when a read happens too
   assign wr_acc_c  = dv_in && (!full_c || rd_c);
   assign ovf_set_c = dv_in && full_c && !rd_c;

   // Settings registers
   always_ff @(posedge clock) begin
      if (reset) begin
         period_q <= CNT_WIDTH'(DEF_PERIOD);
         enable_q <= 1'b1;
         mode_q   <= 1'b0;
         burst_q  <= 8'd1;
      end else begin
         if (period_wr_c) period_q <= set_data[CNT_WIDTH-1:0];
         if (ctrl_wr_c) begin
            enable_q <= set_data[0];
            mode_q   <= set_data[1];
            burst_q  <= set_data[15:8];
         end
      end
   end

   // Period counter: runs only while pacing, restarts on a period write
   always_ff @(posedge clock) begin
      if (reset || period_wr_c || !counting_c) cnt_q <= '0;
      else if (cnt_q == period_q)              cnt_q <= '0;
      else                                     cnt_q <= cnt_q + CNT_WIDTH'(1);
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // Next-state and read decision; the tick itself issues the first read of a burst
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      rd_c           = 1'b0;
      underrun_evt_c = 1'b0;
      if (!enable_q) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = mode_q ? PASS : WAIT;
            WAIT: begin
               if (mode_q) begin
                  state_d = PASS;
               end else if (tick_c) begin
                  if (!empty_c) begin
                     rd_c    = 1'b1;
                     rem_d   = burst_eff_c - 8'd1;
                     state_d = BURST;
                  end else begin
                     underrun_evt_c = 1'b1;
                  end
               end
            end
            BURST: begin
               if (mode_q) begin
                  state_d = PASS;
               end else if (rem_q == 8'd0) begin
                  state_d = WAIT;
               end else if (empty_c) begin
                  underrun_evt_c = 1'b1;
                  state_d        = WAIT;
               end else begin
                  rd_c  = 1'b1;
                  rem_d = rem_q - 8'd1;
               end
            end
            PASS: begin
               if (!mode_q)       state_d = WAIT;
               else if (!empty_c) rd_c    = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FIFO storage (contents need no reset; pointers define validity)
   always_ff @(posedge clock) begin
      if (wr_acc_c) mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in;
   end

   // FIFO pointers, level, overflow and registered read port
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         dv_out     <= 1'b0;
         data_out   <= '0;
      end else begin
         if (wr_acc_c) wr_ptr <= wr_ptr + PW'(1);
         if (rd_c)     rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc_c, rd_c})
            2'b10:   fifo_level <= fifo_level + PW'(1);
            2'b01:   fifo_level <= fifo_level - PW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (ovf_set_c)      overflow <= 1'b1;
         else if (ovf_clr_c) overflow <= 1'b0;
         dv_out <= rd_c;
         if (rd_c) data_out <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
   end

`ifdef SYNC_UNDERRUN_CNT_EN
   // Saturating count of empty ticks and truncated bursts
   always_ff @(posedge clock) begin
      if (reset || ovf_clr_c)                         underrun_cnt <= 16'd0;
      else if (underrun_evt_c && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_paced_data_synchronizer.sv
// Directed bench for paced_data_synchronizer: pacing, bursts, overflow,
// passthrough, truncated bursts and reset mid-burst.
module tb_paced_data_synchronizer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic [31:0] data_in = 32'd0;
   logic        dv_in = 1'b0;
   logic [31:0] data_out;
   logic        dv_out;
   logic [4:0]  fifo_level;
   logic        overflow;
`ifdef SYNC_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   paced_data_synchronizer dut (
      .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
      .set_data(set_data), .data_in(data_in), .dv_in(dv_in),
      .data_out(data_out), .dv_out(dv_out), .fifo_level(fifo_level),
      .overflow(overflow)
`ifdef SYNC_UNDERRUN_CNT_EN
      , .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1; set_stb = 1'b0; dv_in = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic setreg(input logic [7:0] a, input logic [31:0] d);
      set_stb = 1'b1; set_addr = a; set_data = d;
      cyc();
      set_stb = 1'b0;
   endtask

   task automatic write_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         dv_in = 1'b1; data_in = base + 32'(i);
         cyc();
      end
      dv_in = 1'b0;
   endtask

   initial begin
      // Reset values, then default pacing: one word every 10 cycles
      cyc();
      do_reset();
      check("rst_dv", 32'(dv_out), 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      for (int n = 1; n <= 32; n++) begin
         dv_in = (n <= 3); data_in = 32'hA + 32'(n - 1);
         cyc();
         check("t1_dv", 32'(dv_out), (n == 11 || n == 21 || n == 31) ? 32'd1 : 32'd0);
         if (n == 11) check("t1_dataA", data_out, 32'hA);
         if (n == 21) check("t1_dataB", data_out, 32'hB);
         if (n == 31) check("t1_dataC", data_out, 32'hC);
         if (n == 3)  check("t1_level3", 32'(fifo_level), 32'd3);
         if (n == 11) check("t1_level11", 32'(fifo_level), 32'd2);
      end
      dv_in = 1'b0;

      // period=0, B=4, 6 words: 4 back-to-back, gap, then 2 more
      do_reset();
      setreg(8'd1, 32'h0400);
      setreg(8'd0, 32'd0);
      write_words(6, 32'h20);
      setreg(8'd1, 32'h0401);
      for (int p = 1; p <= 9; p++) begin
         cyc();
         check("t2_dv", 32'(dv_out),
               (p >= 2 && p <= 5) || p == 7 || p == 8 ? 32'd1 : 32'd0);
         if (p >= 2 && p <= 5) check("t2_data", data_out, 32'h20 + 32'(p - 2));
         if (p == 7 || p == 8) check("t2_data", data_out, 32'h24 + 32'(p - 7));
      end

      // Disabled, 18 writes into 16 slots: overflow, then clear
      do_reset();
      setreg(8'd1, 32'h0100);
      write_words(18, 32'h100);
      check("t3_level", 32'(fifo_level), 32'd16);
      check("t3_ovf", 32'(overflow), 32'd1);
      setreg(8'd1, 32'h0104);
      check("t3_ovf_clr", 32'(overflow), 32'd0);
      check("t3_level_kept", 32'(fifo_level), 32'd16);

      // Full FIFO in passthrough with dv_in held: read+write each cycle
      setreg(8'd1, 32'h0103);
      cyc();
      for (int k = 2; k <= 21; k++) begin
         dv_in = 1'b1; data_in = 32'h200 + 32'(k - 2);
         cyc();
         check("t4_dv", 32'(dv_out), 32'd1);
         check("t4_data", data_out, (k <= 17) ? 32'h100 + 32'(k - 2) : 32'h200 + 32'(k - 18));
         check("t4_level", 32'(fifo_level), 32'd16);
         check("t4_ovf", 32'(overflow), 32'd0);
      end
      dv_in = 1'b0;

      // B=8 with only 3 words: burst truncated by empty
      do_reset();
      setreg(8'd1, 32'h0800);
      write_words(3, 32'h50);
      setreg(8'd1, 32'h0801);
      for (int p = 1; p <= 15; p++) begin
         cyc();
         check("t5_dv", 32'(dv_out), (p >= 11 && p <= 13) ? 32'd1 : 32'd0);
         if (p >= 11 && p <= 13) check("t5_data", data_out, 32'h50 + 32'(p - 11));
         if (p == 13) check("t5_level", 32'(fifo_level), 32'd0);
`ifdef SYNC_UNDERRUN_CNT_EN
         if (p == 15) check("t5_underrun", 32'(underrun_cnt), 32'd1);
`endif
      end

      // Reset in the middle of a burst, then default period restored
      do_reset();
      setreg(8'd1, 32'h0400);
      setreg(8'd0, 32'd0);
      write_words(6, 32'h30);
      setreg(8'd1, 32'h0401);
      for (int p = 1; p <= 3; p++) cyc();
      check("t6_pre_dv", 32'(dv_out), 32'd1);
      reset = 1'b1;
      cyc();
      check("t6_rst_dv", 32'(dv_out), 32'd0);
      check("t6_rst_level", 32'(fifo_level), 32'd0);
      reset = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         dv_in = (n == 1); data_in = 32'hD;
         cyc();
         check("t6_dv", 32'(dv_out), (n == 11) ? 32'd1 : 32'd0);
         if (n == 11) check("t6_data", data_out, 32'hD);
      end
      dv_in = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
